fpu_wb_queue: RTL and testbench

- Write-back serializer directly upstream of the FPR register file.
- Accepts FPU results from two producers, the FPU execute pipe and the FP load path, and buffers them in a small FIFO.
- Presents exactly one register write per cycle on the register file's single write port (Rn id / Rn value / store mode).
- Provides a scoreboard query so decode can stall on a pending FPR/FPUL write.

---
 rtl/fpu_wb_queue_pkg.sv | 42 ++++
 rtl/fpu_wb_match.sv | 34 +++
 rtl/fpu_wb_queue.sv | 177 +++++++++++++++++
 tb/tb_fpu_wb_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_wb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : CoreDefs (package)
// Purpose  : Shared register-id and store-mode definitions for the FPU
//            write-back path: UREG_FPUL / UREG_NONE ids, FPST_* store-mode
//            encodings, the FPR class test and the queue entry record.
// Revision : 1.0 - initial release
// ============================================================================
package CoreDefs;

    // Unit register ids outside the FPR bank (FPR bank is id[6:5] == 2'b10)
    localparam logic [6:0] UREG_FPUL = 7'h70;
    localparam logic [6:0] UREG_NONE = 7'h7F;

    // Store-mode encodings presented to the register file
    localparam logic [1:0] FPST_FLOAT  = 2'b00;
    localparam logic [1:0] FPST_DOUBLE = 2'b01;
    localparam logic [1:0] FPST_RAWF   = 2'b10;
    localparam logic [1:0] FPST_RAWD   = 2'b11;

    typedef struct packed {
        logic [6:0]  id;
        logic [63:0] val;
        logic [1:0]  mode;
    } wb_entry_t;

    function automatic logic is_fpr(input logic [6:0] id);
        return id[6:5] == 2'b10;
    endfunction

    // Ids the FPR register file actually stores; everything else is dropped
    function automatic logic is_wb_target(input logic [6:0] id);
        return is_fpr(id) || (id == UREG_FPUL);
    endfunction

    // Double-width writes occupy an even/odd FPR pair
    function automatic logic is_double(input logic [1:0] mode);
        return (mode == FPST_DOUBLE) || (mode == FPST_RAWD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_wb_match.sv
`default_nettype none
// ============================================================================
// Module   : fpu_wb_match
// Purpose  : Combinational scoreboard compare of one queued write against one
//            decode query id. A double-mode FPR entry covers both registers
//            of its pair (id[4:1]); all other ids need an exact match.
//            UREG_NONE never matches.
// Ports    : i_valid  - entry holds a live write
//            i_id     - entry destination id
//            i_mode   - entry store mode
//            i_qid    - query id from decode
//            o_match  - entry blocks the queried register
// Revision : 1.0 - initial release
// ============================================================================
module fpu_wb_match
    import CoreDefs::*;
(
    input  logic       i_valid,
    input  logic [6:0] i_id,
    input  logic [1:0] i_mode,
    input  logic [6:0] i_qid,
    output logic       o_match
);

    logic w_pair;

    // Pair compare only applies when both sides are FPRs; FPUL stays exact
    assign w_pair  = is_double(i_mode) && is_fpr(i_id) && is_fpr(i_qid);

    assign o_match = i_valid && (i_id != UREG_NONE) &&
                     (w_pair ? (i_id[4:1] == i_qid[4:1]) : (i_id == i_qid));

endmodule
`default_nettype wire

// File: rtl/fpu_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : fpu_wb_queue
// Purpose  : Write-back serializer in front of the single-write-port FPR
//            register file. Buffers results from the FP load path and the FPU
//            execute pipe in a DEPTH-entry FIFO, emits one write per cycle
//            from the head, and answers two scoreboard queries for decode.
// Ports    : clock/reset          - core clock, async active-high reset
//            ld*/ex*              - producer valid/id/value/mode, ready out
//            wbIdRn/wbValRn/
//            wbStMode             - register file write (UREG_NONE = idle)
//            qIdA/qIdB, qBusy     - scoreboard queries and busy result
//            wbCount              - FIFO occupancy
// Config   : `define FPU_WB_BYPASS_EN lets a result arriving at an empty queue
//            drive wb* in the same cycle instead of being enqueued.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_wb_queue
    import CoreDefs::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          exValid,
    input  logic [6:0]    exIdRn,
    input  logic [63:0]   exValRn,
    input  logic [1:0]    exStMode,
    output logic          exReady,
    input  logic          ldValid,
    input  logic [6:0]    ldIdRn,
    input  logic [63:0]   ldValRn,
    input  logic [1:0]    ldStMode,
    output logic          ldReady,
    output logic [6:0]    wbIdRn,
    output logic [63:0]   wbValRn,
    output logic [1:0]    wbStMode,
    input  logic [6:0]    qIdA,
    input  logic [6:0]    qIdB,
    output logic          qBusy,
    output logic [CW-1:0] wbCount
);

    localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] C_DEPTH_W   = DEPTH[CW:0];

    wb_entry_t     r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;

    logic          w_nonempty;
    logic [CW:0]   w_space;
    logic          w_ld_tgt;
    logic          w_ex_tgt;
    logic          w_byp_ld;
    logic          w_byp_ex;
    logic          w_ld_enq;
    logic          w_ex_enq;
    logic          w_deq;
    logic [AW-1:0] w_ex_slot;
    wb_entry_t     w_ld_ent;
    wb_entry_t     w_ex_ent;
    logic [DEPTH-1:0] w_hit_a;
    logic [DEPTH-1:0] w_hit_b;

    assign w_nonempty = (r_count != '0);

    // The head leaves at the same edge new entries land, so its slot counts
    // as free this cycle.
    assign w_space = C_DEPTH_W - {1'b0, r_count} + (CW+1)'(w_nonempty);

    // Load has fixed priority: execute needs a second free slot if load is
    // also presenting.
    assign ldReady = (w_space != '0);
    assign exReady = ldValid ? (w_space > (CW+1)'(1)) : (w_space != '0);

    // Accepted results bound for the FPR file; other ids are acked and dropped
    assign w_ld_tgt = ldValid && ldReady && is_wb_target(ldIdRn);
    assign w_ex_tgt = exValid && exReady && is_wb_target(exIdRn);

`ifdef FPU_WB_BYPASS_EN
    // Empty queue: one result goes straight to the write port. When both
    // arrive, load takes the bypass and execute queues behind it.
    assign w_byp_ld = !w_nonempty && w_ld_tgt;
    assign w_byp_ex = !w_nonempty && w_ex_tgt && !w_ld_tgt;
`else
    assign w_byp_ld = 1'b0;
    assign w_byp_ex = 1'b0;
`endif

    assign w_ld_enq  = w_ld_tgt && !w_byp_ld;
    assign w_ex_enq  = w_ex_tgt && !w_byp_ex;
    assign w_deq     = w_nonempty;

    // Execute lands behind load when both enqueue, keeping program order
    assign w_ex_slot = r_wr_ptr + AW'(w_ld_enq);

    assign w_ld_ent  = '{id: ldIdRn, val: ldValRn, mode: ldStMode};
    assign w_ex_ent  = '{id: exIdRn, val: exValRn, mode: exStMode};

    // Payload storage needs no reset: r_count gates every read of it
    always_ff @(posedge clock) begin
        if (w_ld_enq) begin
            r_mem[r_wr_ptr] <= w_ld_ent;
        end
        if (w_ex_enq) begin
            r_mem[w_ex_slot] <= w_ex_ent;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= r_count + CW'(w_ld_enq) + CW'(w_ex_enq) - CW'(w_deq);
            r_rd_ptr <= r_rd_ptr + AW'(w_deq);
            r_wr_ptr <= r_wr_ptr + AW'(w_ld_enq) + AW'(w_ex_enq);
        end
    end

    // Write port: head entry, else bypassed result, else idle
    always_comb begin
        wbIdRn   = UREG_NONE;
        wbValRn  = '0;
        wbStMode = FPST_FLOAT;
        if (w_nonempty) begin
            wbIdRn   = r_mem[r_rd_ptr].id;
            wbValRn  = r_mem[r_rd_ptr].val;
            wbStMode = r_mem[r_rd_ptr].mode;
        end else if (w_byp_ld) begin
            wbIdRn   = ldIdRn;
            wbValRn  = ldValRn;
            wbStMode = ldStMode;
        end else if (w_byp_ex) begin
            wbIdRn   = exIdRn;
            wbValRn  = exValRn;
            wbStMode = exStMode;
        end
    end

    // Scoreboard: slot i is live when its distance from the read pointer is
    // below the occupancy. Bypassed and in-flight handshakes are not visible.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_match
            logic [AW-1:0] w_dist;
            logic          w_live;

            assign w_dist = AW'(i) - r_rd_ptr;
            assign w_live = (CW'(w_dist) < r_count);

            fpu_wb_match u_match_a (
                .i_valid (w_live),
                .i_id    (r_mem[i].id),
                .i_mode  (r_mem[i].mode),
                .i_qid   (qIdA),
                .o_match (w_hit_a[i])
            );

            fpu_wb_match u_match_b (
                .i_valid (w_live),
                .i_id    (r_mem[i].id),
                .i_mode  (r_mem[i].mode),
                .i_qid   (qIdB),
                .o_match (w_hit_b[i])
            );
        end
    endgenerate

    assign qBusy   = |(w_hit_a | w_hit_b);
    assign wbCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fpu_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_wb_queue
// Purpose  : Directed self-checking bench for fpu_wb_queue (DEPTH=4, FIFO
//            build). Inputs change on the falling edge; outputs are sampled
//            before the next rising edge. A register-file model records
//            every write the queue emits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_wb_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        exValid, ldValid;
    logic [6:0]  exIdRn, ldIdRn;
    logic [63:0] exValRn, ldValRn;
    logic [1:0]  exStMode, ldStMode;
    logic        exReady, ldReady;
    logic [6:0]  wbIdRn;
    logic [63:0] wbValRn;
    logic [1:0]  wbStMode;
    logic [6:0]  qIdA, qIdB;
    logic        qBusy;
    logic [2:0]  wbCount;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] rf [128] = '{default: 64'h0};

    // Saturation scenario: occupancy, head id and execute-ready per cycle
    logic [2:0] exp_cnt  [13] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4,
                                  3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic [6:0] exp_head [13] = '{7'h7F, 7'h40, 7'h50, 7'h41, 7'h51, 7'h42,
                                  7'h52, 7'h43, 7'h44, 7'h45, 7'h46, 7'h47,
                                  7'h7F};
    logic       exp_exr  [8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0};

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (wbIdRn !== 7'h7F) rf[wbIdRn] <= wbValRn;
    end

    fpu_wb_queue #(.DEPTH(4), .CW(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .exValid  (exValid),
        .exIdRn   (exIdRn),
        .exValRn  (exValRn),
        .exStMode (exStMode),
        .exReady  (exReady),
        .ldValid  (ldValid),
        .ldIdRn   (ldIdRn),
        .ldValRn  (ldValRn),
        .ldStMode (ldStMode),
        .ldReady  (ldReady),
        .wbIdRn   (wbIdRn),
        .wbValRn  (wbValRn),
        .wbStMode (wbStMode),
        .qIdA     (qIdA),
        .qIdB     (qIdB),
        .qBusy    (qBusy),
        .wbCount  (wbCount)
    );

    task automatic idle_inputs;
        ldValid = 1'b0; ldIdRn = 7'h7F; ldValRn = '0; ldStMode = 2'b00;
        exValid = 1'b0; exIdRn = 7'h7F; exValRn = '0; exStMode = 2'b00;
        qIdA = 7'h7F; qIdB = 7'h7F;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        ldValid = 1'b1; ldIdRn = 7'h41; ldValRn = 64'h11; ldStMode = 2'b00;
        exValid = 1'b1; exIdRn = 7'h43; exValRn = 64'h33; exStMode = 2'b01;
        qIdA = 7'h41;
        repeat (2) @(negedge clock);
        #4;
        n_checks++; if (wbIdRn !== 7'h7F) begin n_fail++; $display("FAIL rst_id: got %h want 7f", wbIdRn); end
        n_checks++; if (wbValRn !== 64'h0) begin n_fail++; $display("FAIL rst_val: got %h want 0", wbValRn); end
        n_checks++; if (wbStMode !== 2'b00) begin n_fail++; $display("FAIL rst_mode: got %b want 00", wbStMode); end
        n_checks++; if (wbCount !== 3'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", wbCount); end
        n_checks++; if (qBusy !== 1'b0) begin n_fail++; $display("FAIL rst_qbusy: got %b want 0", qBusy); end
        @(negedge clock);
        reset = 1'b0;
        #4;
        n_checks++; if (wbIdRn !== 7'h7F) begin n_fail++; $display("FAIL rel_id: got %h want 7f", wbIdRn); end
        n_checks++; if (wbCount !== 3'd0) begin n_fail++; $display("FAIL rel_cnt: got %0d want 0", wbCount); end
        @(negedge clock);
        ldValid = 1'b0; exValid = 1'b0;
        #4;
        n_checks++; if (wbIdRn !== 7'h41 || wbValRn !== 64'h11) begin n_fail++; $display("FAIL first_wb: got %h/%h want 41/11", wbIdRn, wbValRn); end
        n_checks++; if (wbCount !== 3'd2) begin n_fail++; $display("FAIL first_cnt: got %0d want 2", wbCount); end
        n_checks++; if (qBusy !== 1'b1) begin n_fail++; $display("FAIL first_qbusy: got %b want 1", qBusy); end
        @(negedge clock);
        #4;
        n_checks++; if (wbIdRn !== 7'h43 || wbValRn !== 64'h33 || wbStMode !== 2'b01) begin n_fail++; $display("FAIL second_wb: got %h/%h/%b want 43/33/01", wbIdRn, wbValRn, wbStMode); end
        @(negedge clock);
        qIdA = 7'h7F;
        #4;
        n_checks++; if (wbIdRn !== 7'h7F || wbCount !== 3'd0) begin n_fail++; $display("FAIL drained: got id %h cnt %0d want 7f/0", wbIdRn, wbCount); end
    endtask

    task automatic test_simultaneous;
        @(negedge clock);
        ldValid = 1'b1; ldIdRn = 7'h42; ldValRn = 64'd1; ldStMode = 2'b01;
        exValid = 1'b1; exIdRn = 7'h42; exValRn = 64'd2; exStMode = 2'b01;
        #4;
        n_checks++; if (ldReady !== 1'b1 || exReady !== 1'b1) begin n_fail++; $display("FAIL sim_ready: got ld %b ex %b want 1/1", ldReady, exReady); end
        @(negedge clock);
        idle_inputs();
        #4;
        n_checks++; if (wbIdRn !== 7'h42 || wbValRn !== 64'd1) begin n_fail++; $display("FAIL sim_first: got %h/%0d want 42/1", wbIdRn, wbValRn); end
        @(negedge clock);
        #4;
        n_checks++; if (wbIdRn !== 7'h42 || wbValRn !== 64'd2) begin n_fail++; $display("FAIL sim_second: got %h/%0d want 42/2", wbIdRn, wbValRn); end
        @(negedge clock);
        #4;
        n_checks++; if (rf[7'h42] !== 64'd2) begin n_fail++; $display("FAIL sim_final_reg: got %0d want 2", rf[7'h42]); end
        n_checks++; if (wbIdRn !== 7'h7F) begin n_fail++; $display("FAIL sim_idle: got %h want 7f", wbIdRn); end
    endtask

    task automatic test_full;
        int ex_idx = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clock);
            if (c < 8) begin
                ldValid = 1'b1; ldIdRn = 7'h40 + 7'(c); ldValRn = 64'(7'h40 + 7'(c)); ldStMode = 2'b01;
                exValid = 1'b1; exIdRn = 7'h50 + 7'(ex_idx); exValRn = 64'(7'h50 + 7'(ex_idx)); exStMode = 2'b01;
            end else begin
                idle_inputs();
            end
            #4;
            n_checks++; if (wbCount !== exp_cnt[c]) begin n_fail++; $display("FAIL full_cnt[%0d]: got %0d want %0d", c, wbCount, exp_cnt[c]); end
            n_checks++; if (wbIdRn !== exp_head[c]) begin n_fail++; $display("FAIL full_head[%0d]: got %h want %h", c, wbIdRn, exp_head[c]); end
            if (exp_head[c] != 7'h7F) begin
                n_checks++; if (wbValRn !== 64'(exp_head[c])) begin n_fail++; $display("FAIL full_val[%0d]: got %h want %h", c, wbValRn, exp_head[c]); end
            end
            if (c < 8) begin
                n_checks++; if (ldReady !== 1'b1) begin n_fail++; $display("FAIL full_ldr[%0d]: got %b want 1", c, ldReady); end
                n_checks++; if (exReady !== exp_exr[c]) begin n_fail++; $display("FAIL full_exr[%0d]: got %b want %b", c, exReady, exp_exr[c]); end
                if (exp_exr[c]) ex_idx++;
            end
        end
    endtask

    task automatic test_scoreboard;
        @(negedge clock);
        exValid = 1'b1; exIdRn = 7'h44; exValRn = 64'h5; exStMode = 2'b01;
        qIdA = 7'h44; qIdB = 7'h7F;
        #4;
        n_checks++; if (qBusy !== 1'b0) begin n_fail++; $display("FAIL sb_same_cycle: got %b want 0", qBusy); end
        @(negedge clock);
        idle_inputs();
        qIdA = 7'h45; qIdB = 7'h20;
        #2;
        n_checks++; if (qBusy !== 1'b1) begin n_fail++; $display("FAIL sb_double_pair: got %b want 1", qBusy); end
        qIdA = 7'h46;
        #2;
        n_checks++; if (qBusy !== 1'b0) begin n_fail++; $display("FAIL sb_other_pair: got %b want 0", qBusy); end
        @(negedge clock);
        exValid = 1'b1; exIdRn = 7'h44; exValRn = 64'h6; exStMode = 2'b00;
        qIdA = 7'h7F; qIdB = 7'h7F;
        #4;
        n_checks++; if (qBusy !== 1'b0) begin n_fail++; $display("FAIL sb_none_query: got %b want 0", qBusy); end
        @(negedge clock);
        idle_inputs();
        qIdA = 7'h45;
        #2;
        n_checks++; if (qBusy !== 1'b0) begin n_fail++; $display("FAIL sb_float_pair: got %b want 0", qBusy); end
        qIdB = 7'h44;
        #2;
        n_checks++; if (qBusy !== 1'b1) begin n_fail++; $display("FAIL sb_float_exact_b: got %b want 1", qBusy); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_discard;
        @(negedge clock);
        exValid = 1'b1; exIdRn = 7'h10; exValRn = 64'hDEAD; exStMode = 2'b00;
        #4;
        n_checks++; if (exReady !== 1'b1) begin n_fail++; $display("FAIL gpr_ready: got %b want 1", exReady); end
        @(negedge clock);
        idle_inputs();
        #4;
        n_checks++; if (wbCount !== 3'd0 || wbIdRn !== 7'h7F) begin n_fail++; $display("FAIL gpr_dropped: got cnt %0d id %h want 0/7f", wbCount, wbIdRn); end
        n_checks++; if (rf[7'h10] !== 64'h0) begin n_fail++; $display("FAIL gpr_no_write: got %h want 0", rf[7'h10]); end
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        ldValid = 1'b1; ldIdRn = 7'h48; ldValRn = 64'h48; ldStMode = 2'b00;
        exValid = 1'b1; exIdRn = 7'h49; exValRn = 64'h49; exStMode = 2'b00;
        @(negedge clock);
        ldIdRn = 7'h4A; ldValRn = 64'h4A;
        exIdRn = 7'h4B; exValRn = 64'h4B;
        #4;
        n_checks++; if (wbCount !== 3'd2 || wbIdRn !== 7'h48) begin n_fail++; $display("FAIL mid_pre: got cnt %0d id %h want 2/48", wbCount, wbIdRn); end
        @(negedge clock);
        idle_inputs();
        #2;
        n_checks++; if (wbCount !== 3'd3 || wbIdRn !== 7'h49) begin n_fail++; $display("FAIL mid_three: got cnt %0d id %h want 3/49", wbCount, wbIdRn); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (wbCount !== 3'd0 || wbIdRn !== 7'h7F) begin n_fail++; $display("FAIL mid_async: got cnt %0d id %h want 0/7f", wbCount, wbIdRn); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #4;
        n_checks++; if (wbIdRn !== 7'h7F) begin n_fail++; $display("FAIL mid_after: got %h want 7f", wbIdRn); end
        @(negedge clock);
        #4;
        n_checks++; if (wbIdRn !== 7'h7F || wbCount !== 3'd0) begin n_fail++; $display("FAIL mid_after2: got id %h cnt %0d want 7f/0", wbIdRn, wbCount); end
        n_checks++; if (rf[7'h48] !== 64'h48) begin n_fail++; $display("FAIL mid_written: got %h want 48", rf[7'h48]); end
        n_checks++; if (rf[7'h49] !== 64'h0 || rf[7'h4A] !== 64'h0 || rf[7'h4B] !== 64'h0) begin n_fail++; $display("FAIL mid_dropped: got %h %h %h want 0 0 0", rf[7'h49], rf[7'h4A], rf[7'h4B]); end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_full();
        test_scoreboard();
        test_discard();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
